// File: rtl/msk_rnd_provider.sv
// msk_rnd_provider
// Randomness source for masked gadgets. A 128-bit Fibonacci LFSR is seeded
// with four 32-bit beats, optionally warmed up, and then delivers RND_W
// fresh bits per accepted valid/ready transfer.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   seed_in/seed_valid/      32-bit seed beat handshake; beat b lands in
//   seed_ready               S[32*b +: 32], b = 0..3
//   reseed                   single-cycle request to restart seeding
//   rnd_out/rnd_valid/       RND_W random bits per transfer
//   rnd_ready
//   reseed_req               MAX_OUT transfers used up; a new seed is needed

`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_rnd_provider #(
    parameter int D       = `DEFAULTSHARES,
    parameter int RND_W   = D * (D - 1),
    parameter int WARMUP  = 128,
    parameter int MAX_OUT = 1 << 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      seed_in,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             reseed,
    output logic [RND_W-1:0] rnd_out,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             reseed_req
);

    typedef enum logic [1:0] {ST_UNSEEDED, ST_LOAD, ST_WARMUP, ST_RUN} state_t;

    localparam logic [31:0] WARM_LAST = 32'(WARMUP - 1);
    localparam logic [31:0] OUT_LAST  = 32'(MAX_OUT - 1);

    state_t           state_reg, state_next;
    logic [127:0]     s_reg;
    logic [RND_W-1:0] out_reg;
    logic             valid_reg;
    logic             req_reg;
    logic [1:0]       beat_reg;
    logic [31:0]      warm_reg;
    logic [31:0]      cnt_reg;

    // Unrolled advance: RND_W LFSR steps in one cycle, bit k = feedback of step k.
    logic [127:0]     chain [0:RND_W];
    logic [RND_W-1:0] adv_bits;
    logic [127:0]     adv_state;

    assign chain[0] = s_reg;
    generate
        for (genvar gi = 0; gi < RND_W; gi++) begin : g_step
            assign adv_bits[gi]  = chain[gi][127] ^ chain[gi][125] ^ chain[gi][100] ^ chain[gi][98];
            assign chain[gi + 1] = {chain[gi][126:0], adv_bits[gi]};
        end
    endgenerate
    assign adv_state = chain[RND_W];

    logic seed_fire, rnd_fire, reseed_ok, last_beat, warm_done, limit_hit;

    assign seed_fire = (state_reg == ST_LOAD) && seed_valid;
    assign rnd_fire  = valid_reg && rnd_ready;
    assign reseed_ok = reseed && (state_reg != ST_UNSEEDED);
    assign last_beat = seed_fire && (beat_reg == 2'd3);
    assign warm_done = (state_reg == ST_WARMUP) && (warm_reg == WARM_LAST);
    assign limit_hit = rnd_fire && (MAX_OUT != 0) && (cnt_reg == OUT_LAST);

    // State after writing the current beat; the all-zero seed would lock the
    // LFSR, so a completed zero seed is nudged to 1.
    logic [127:0] s_load;
    always_comb begin
        s_load = s_reg;
        s_load[32*beat_reg +: 32] = seed_in;
        if (beat_reg == 2'd3 && s_load == 128'd0)
            s_load[0] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ST_UNSEEDED;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_UNSEEDED: state_next = ST_LOAD;
            ST_LOAD:     if (last_beat) state_next = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            ST_WARMUP:   if (warm_done) state_next = ST_RUN;
            ST_RUN:      if (limit_hit) state_next = ST_LOAD;
            default:     state_next = ST_UNSEEDED;
        endcase
        // Reseed wins over everything, including MAX_OUT expiry.
        if (reseed_ok)
            state_next = ST_LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg     <= '0;
            out_reg   <= '0;
            valid_reg <= 1'b0;
            req_reg   <= 1'b0;
            beat_reg  <= '0;
            warm_reg  <= '0;
            cnt_reg   <= '0;
        end else if (reseed_ok) begin
            // A coincident fire has already been taken by the consumer; the
            // partially loaded S is left in place and overwritten by new beats.
            valid_reg <= 1'b0;
            req_reg   <= 1'b0;
            beat_reg  <= '0;
            warm_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (seed_fire) begin
                        s_reg    <= s_load;
                        req_reg  <= 1'b0;
                        beat_reg <= last_beat ? 2'd0 : beat_reg + 2'd1;
                    end
                end
                ST_WARMUP: begin
                    s_reg    <= adv_state;
                    warm_reg <= warm_done ? 32'd0 : warm_reg + 32'd1;
                end
                ST_RUN: begin
                    if (!valid_reg) begin
                        // First advance after seeding fills the output register.
                        s_reg     <= adv_state;
                        out_reg   <= adv_bits;
                        valid_reg <= 1'b1;
                    end else if (limit_hit) begin
                        valid_reg <= 1'b0;
                        req_reg   <= 1'b1;
                        cnt_reg   <= '0;
                    end else if (rnd_fire) begin
                        s_reg   <= adv_state;
                        out_reg <= adv_bits;
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign seed_ready = (state_reg == ST_LOAD);
    assign rnd_out    = out_reg;
    assign rnd_valid  = valid_reg;
    assign reseed_req = req_reg;

endmodule

// File: tb/tb_msk_rnd_provider.sv
// tb_msk_rnd_provider
// Directed bench for msk_rnd_provider. Two instances with RND_W=2:
//   dut_a: WARMUP=0, MAX_OUT=0 (unlimited)  -- reset, zero seed, backpressure,
//          reseed handling, asynchronous reset
//   dut_b: WARMUP=3, MAX_OUT=4              -- warm-up and reseed demand
// Expected bit streams come from a small LFSR reference model or hand values.

module tb_msk_rnd_provider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_seed_valid, a_seed_ready, a_reseed, a_rnd_valid, a_rnd_ready, a_reseed_req;
    logic [31:0] a_seed_in;
    logic [1:0]  a_rnd_out;
    logic        b_rst, b_seed_valid, b_seed_ready, b_reseed, b_rnd_valid, b_rnd_ready, b_reseed_req;
    logic [31:0] b_seed_in;
    logic [1:0]  b_rnd_out;

    msk_rnd_provider #(.D(2), .RND_W(2), .WARMUP(0), .MAX_OUT(0)) dut_a (
        .clk(clk), .rst(a_rst), .seed_in(a_seed_in), .seed_valid(a_seed_valid),
        .seed_ready(a_seed_ready), .reseed(a_reseed), .rnd_out(a_rnd_out),
        .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready), .reseed_req(a_reseed_req)
    );

    msk_rnd_provider #(.D(2), .RND_W(2), .WARMUP(3), .MAX_OUT(4)) dut_b (
        .clk(clk), .rst(b_rst), .seed_in(b_seed_in), .seed_valid(b_seed_valid),
        .seed_ready(b_seed_ready), .reseed(b_reseed), .rnd_out(b_rnd_out),
        .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready), .reseed_req(b_reseed_req)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: n-th transfer (1-based) after a seed, RND_W=2.
    function automatic logic [1:0] model(input logic [127:0] seed, input int warm, input int n);
        logic [127:0] s;
        logic         fb;
        logic [1:0]   r;
        s = (seed == 128'd0) ? 128'd1 : seed;
        for (int i = 0; i < (warm + n - 1) * 2; i++) begin
            fb = s[127] ^ s[125] ^ s[100] ^ s[98];
            s  = {s[126:0], fb};
        end
        r = 2'b00;
        for (int k = 0; k < 2; k++) begin
            fb   = s[127] ^ s[125] ^ s[100] ^ s[98];
            s    = {s[126:0], fb};
            r[k] = fb;
        end
        return r;
    endfunction

    function automatic logic sel_valid(input int sel);
        return (sel == 0) ? a_rnd_valid : b_rnd_valid;
    endfunction
    function automatic logic sel_ready(input int sel);
        return (sel == 0) ? a_seed_ready : b_seed_ready;
    endfunction
    function automatic logic [1:0] sel_out(input int sel);
        return (sel == 0) ? a_rnd_out : b_rnd_out;
    endfunction

    task automatic set_rdy(input int sel, input logic v);
        if (sel == 0) a_rnd_ready = v; else b_rnd_ready = v;
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send_beat(input int sel, input logic [31:0] w);
        int t = 0;
        if (sel == 0) begin a_seed_in = w; a_seed_valid = 1'b1; end
        else          begin b_seed_in = w; b_seed_valid = 1'b1; end
        while (!sel_ready(sel) && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("beat_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        if (sel == 0) a_seed_valid = 1'b0; else b_seed_valid = 1'b0;
    endtask

    task automatic send_seed(input int sel, input logic [127:0] x);
        for (int b = 0; b < 4; b++) send_beat(sel, x[32*b +: 32]);
    endtask

    task automatic wait_valid(input int sel);
        int t = 0;
        while (!sel_valid(sel) && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) check("valid_timeout", 0, 1);
    endtask

    // Back-to-back transfers first..first+n-1, each checked against the model.
    task automatic burst(input int sel, input logic [127:0] seed, input int warm,
                         input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wait_valid(sel);
            $display("xfer dut%0d #%0d out=%b", sel, first + i, sel_out(sel));
            check($sformatf("xfer%0d_%0d", sel, first + i), {126'd0, sel_out(sel)},
                  {126'd0, model(seed, warm, first + i)});
            set_rdy(sel, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        set_rdy(sel, 1'b0);
    endtask

    localparam logic [127:0] SEED_X = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] SEED_Y = 128'hdead_beef_0000_0001_8000_0000_cafe_f00d;
    localparam logic [127:0] SEED_Z = 128'h5555_aaaa_1234_0000_0000_4321_ffff_0001;

    initial begin
        logic [1:0] held;
        a_rst = 1'b1; a_seed_in = '0; a_seed_valid = 1'b0; a_reseed = 1'b0; a_rnd_ready = 1'b0;
        b_rst = 1'b1; b_seed_in = '0; b_seed_valid = 1'b0; b_reseed = 1'b0; b_rnd_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values and one UNSEEDED cycle.
        check("rst_valid", a_rnd_valid, 0);
        check("rst_out", a_rnd_out, 0);
        check("rst_seed_ready", a_seed_ready, 0);
        check("rst_req", a_reseed_req, 0);
        a_rst = 1'b0; b_rst = 1'b0;
        #1 check("unseeded_ready", a_seed_ready, 0);
        @(negedge clk);
        check("load_ready", a_seed_ready, 1);
        check("load_valid", a_rnd_valid, 0);

        // Zero seed: guard sets S[0], bit reaches tap 98 at step 98 -> transfer 50.
        send_seed(0, 128'd0);
        burst(0, 128'd0, 0, 1, 49);
        wait_valid(0);
        check("zero_x50_hand", a_rnd_out, 2'b01);
        set_rdy(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rdy(0, 1'b0);

        // Backpressure: 10 stalled cycles, output must stay on transfer 51.
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", a_rnd_valid, 1);
            check("stall_out", a_rnd_out, model(128'd0, 0, 51));
            @(negedge clk);
        end
        burst(0, 128'd0, 0, 51, 5);

        // Reseed coinciding with a fire: fire taken, no valid until reseeded.
        wait_valid(0);
        held = a_rnd_out;
        check("pre_reseed_out", held, model(128'd0, 0, 56));
        a_rnd_ready = 1'b1; a_reseed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rnd_ready = 1'b0; a_reseed = 1'b0;
        check("reseed_valid", a_rnd_valid, 0);
        check("reseed_ready", a_seed_ready, 1);
        repeat (3) @(negedge clk);
        check("reseed_hold_valid", a_rnd_valid, 0);

        // Reseed mid-LOAD: two junk beats discarded, then a clean load of X.
        send_beat(0, 32'hffff_ffff);
        send_beat(0, 32'h1357_9bdf);
        a_reseed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_reseed = 1'b0;
        send_seed(0, SEED_X);
        burst(0, SEED_X, 0, 1, 6);

        // Asynchronous reset mid-RUN, away from any clock edge.
        wait_valid(0);
        #2 a_rst = 1'b1;
        #1 check("arst_valid", a_rnd_valid, 0);
        check("arst_req", a_reseed_req, 0);
        check("arst_out", a_rnd_out, 0);
        @(negedge clk);
        a_rst = 1'b0;
        #1 check("arst_unseeded", a_seed_ready, 0);
        @(negedge clk);
        check("arst_load", a_seed_ready, 1);

        // MAX_OUT=4 with WARMUP=3 on dut_b.
        send_seed(1, SEED_Y);
        burst(1, SEED_Y, 3, 1, 4);
        check("max_valid", b_rnd_valid, 0);
        check("max_req", b_reseed_req, 1);
        check("max_seed_ready", b_seed_ready, 1);
        send_beat(1, SEED_Z[31:0]);
        check("req_clear", b_reseed_req, 0);
        for (int b = 1; b < 4; b++) send_beat(1, SEED_Z[32*b +: 32]);
        burst(1, SEED_Z, 3, 1, 4);
        check("max2_req", b_reseed_req, 1);
        check("max2_valid", b_rnd_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
